uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter, successor to the fixed 8-bit Tx unit. Accepts words over a valid/ready handshake into a small FIFO and serialises them LSB-first. Frame format is runtime-selectable: data bits, parity mode, stop bits and baud divisor. Sits between the system bus-side logic and the TX pin, and pairs with the UART receiver.

## Interface
- `DATA_W`, 9: maximum data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DIV_W`, 16: width of the baud divisor.
- `clock`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset. The codebase's prior active-low `reset_n` does not apply to this block.
- `s_data`  in  DATA_W: word to transmit; bits above `data_bits` are ignored.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: FIFO not full.
- `data_bits`  in  4: number of data bits, 5..DATA_W.
- `parity_type`  in  2: 00 none, 01 odd, 10 even, 11 none.
- `stop2`  in  1: 0 selects one stop bit, 1 selects two.
- `baud_div`  in  DIV_W: clocks per bit; 0 is treated as 1.
- `data_tx`  out  1: serial line, idle high.
- `active_flag`  out  1: high while a frame is on the line.
- `done_flag`  out  1: one-cycle pulse at the end of each frame.
- `fifo_level`  out  clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- A word is pushed when `s_valid && s_ready` on a clock edge. With `s_valid` and `!s_ready`, the word is held by the source and not dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE:** `data_tx`=1. If the FIFO is non-empty, pop the head, latch the frame configuration, and go to START. The latched fields are `data_bits`, `parity_type`, `stop2` and `baud_div`.
- **Configuration latching:** changes to the configuration mid-frame have no effect until the next frame.
- **START:** `data_tx`=0 for one bit period, then go to DATA.
- **DATA:** shift out `data_bits` bits, LSB first, one bit period each.
  - At the end, go to PARITY if the parity mode is odd or even; otherwise go to STOP.
- **PARITY:** the parity is computed over the `data_bits` LSBs only.
  - Even mode: the bit is the XOR of those bits.
  - Odd mode: the bit is the inverted XOR.
  - Lasts one bit period, then go to STOP.
- **STOP:** `data_tx`=1 for 1 or 2 bit periods.
  - On the last cycle of the final stop bit, `done_flag`=1.
  - If the FIFO is then non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- **Bit timer:** a down-counter reloaded with max(`baud_div`,1) at every bit boundary. A bit ends when the count reaches 1.
- **Bit counter:** counts data bits and stop bits. It is 4 bits wide and saturates at no point.
- **Out-of-range `data_bits`:** values below 5 are clamped to 5; values above DATA_W are clamped to DATA_W.
- **Simultaneous push and pop on a full FIFO:** the pop happens first, so `s_ready` is low that cycle and the push is refused.
- **Simultaneous push and pop on an empty FIFO:** the pop does not see the same-cycle push. That word starts one cycle later.

## Timing
- **Reset values:** `data_tx`=1, `active_flag`=0, `done_flag`=0, `s_ready`=1, `fifo_level`=0, FSM=IDLE. The FIFO is emptied.
- **Reset mid-frame:** the frame is aborted and the line returns high immediately (asynchronously).
- **Latency:** a push at edge N makes the FIFO non-empty after N. IDLE pops at edge N+1. `data_tx` falls after edge N+1, i.e. it is registered out of START.
- **`active_flag`:** high from the START entry edge through the last stop cycle inclusive.
- **Frame length:** (1 + data_bits + P + S) × max(baud_div,1) clocks, where P is 0 or 1 and S is 1 or 2.
- **`s_ready`:** a registered function of FIFO occupancy, never combinational on `s_valid`.
- **`done_flag`:** coincident with the final stop cycle, one cycle wide.

## Structure
- Package `uart_pkg`:
  - `parity_t` enum: NONE, ODD, EVEN, NONE2.
  - `tx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Constants `MIN_DATA_BITS`=5 and `IDLE_LEVEL`=1.
- Sub-module `uart_tx_fifo`:
  - Synchronous FIFO parameterised by DATA_W and FIFO_DEPTH.
  - Ports: push, pop, full, empty, level, data.
  - Pointers are one bit wider than the address.
- Top level contains only the FSM, the bit timer, the bit counter, the shift register and the parity XOR.

## Test plan
- **8N1, div 4, data 0xA5:** `data_tx` is 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks. The frame is 40 clocks and `done_flag` pulses once at clock 40.
- **8E1 and 8O1, div 2, 0xA5:** the parity bit is 0 (even) and 1 (odd). The 7-bit even-parity case with 0x07 gives parity 1. The frame is 22 clocks.
- **5N2, div 3, 0x1F:** 5 ones, then 2 stop bits. The frame is 24 clocks and bits above bit 4 of `s_data` are ignored.
- **FIFO depth 4, push 6 back-to-back words with `s_valid` held:**
  - `s_ready` drops after the FIFO fills; no word is lost.
  - Frames are contiguous with no idle cycle between stop and start.
- **Config change mid-frame:** change div 4→8 and parity none→even during DATA. The current frame is unchanged and the next frame uses the new settings.
- **Reset mid-frame:** assert `reset` during DATA. `data_tx` goes to 1 and `active_flag` to 0 without waiting for a clock edge. `fifo_level` goes to 0, and a later push transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    ODD   = 2'b01,
    EVEN  = 2'b10,
    NONE2 = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;
  localparam logic       IDLE_LEVEL    = 1'b1;

  // Out-of-range requests are pulled into [MIN_DATA_BITS, max_bits].
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < MIN_DATA_BITS) return MIN_DATA_BITS;
    if (req > max_bits) return max_bits;
    return req;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter; head word is visible
// combinationally so the FSM can pop and load it on the same edge.
module uart_tx_fifo #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Extra pointer bit distinguishes full from empty when addresses match.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with runtime frame format; words are queued in a FIFO
// and sent back-to-back, configuration latched at the start of each frame.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [3:0]                  data_bits,
  input  logic [1:0]                  parity_type,
  input  logic                        stop2,
  input  logic [DIV_W-1:0]            baud_div,
  output logic                        data_tx,
  output logic                        active_flag,
  output logic                        done_flag,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam logic [3:0]       MAX_BITS = 4'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_ONE  = 1;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  logic [3:0]        nbits_in;
  logic [DIV_W-1:0]  div_in;
  parity_t           par_in;
  logic [DATA_W-1:0] bit_mask;
  logic [DATA_W-1:0] word_masked;
  logic              parity_in;

  assign nbits_in = clamp_data_bits(data_bits, MAX_BITS);
  assign div_in   = (baud_div == '0) ? DIV_ONE : baud_div;
  assign par_in   = parity_t'(parity_type);

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    assign bit_mask[gi] = (4'(gi) < nbits_in);
  end

  assign word_masked = fifo_data & bit_mask;
  assign parity_in   = (par_in == ODD) ? ~(^word_masked) : (^word_masked);

  tx_state_t         state_reg,  state_next;
  logic [DIV_W-1:0]  timer_reg,  timer_next;
  logic [3:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg,  shift_next;
  logic              parity_reg, parity_next;
  logic [3:0]        nbits_reg,  nbits_next;
  parity_t           par_reg,    par_next;
  logic              stop2_reg,  stop2_next;
  logic [DIV_W-1:0]  div_reg,    div_next;
  logic              tx_reg,     tx_next;
  logic              bit_end;
  logic              load;
  logic              done;

  assign bit_end = (timer_reg == DIV_ONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      timer_reg   <= DIV_ONE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      nbits_reg   <= MIN_DATA_BITS;
      par_reg     <= NONE;
      stop2_reg   <= 1'b0;
      div_reg     <= DIV_ONE;
      tx_reg      <= IDLE_LEVEL;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      nbits_reg   <= nbits_next;
      par_reg     <= par_next;
      stop2_reg   <= stop2_next;
      div_reg     <= div_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    nbits_next   = nbits_reg;
    par_next     = par_reg;
    stop2_next   = stop2_reg;
    div_next     = div_reg;
    load         = 1'b0;
    done         = 1'b0;
    fifo_pop     = 1'b0;
    tx_next      = IDLE_LEVEL;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          timer_next   = div_reg;
          bit_cnt_next = '0;
        end else begin
          timer_next = timer_reg - DIV_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          timer_next = div_reg;
          if (bit_cnt_reg == nbits_reg - 4'd1) begin
            bit_cnt_next = '0;
            state_next   = (par_reg == ODD || par_reg == EVEN) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else begin
          timer_next = timer_reg - DIV_ONE;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next   = STOP;
          timer_next   = div_reg;
          bit_cnt_next = '0;
        end else begin
          timer_next = timer_reg - DIV_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_reg == {3'b000, stop2_reg}) begin
            done = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else state_next = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            timer_next   = div_reg;
          end
        end else begin
          timer_next = timer_reg - DIV_ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame start: take the head word and freeze the format for this frame.
    if (load) begin
      fifo_pop     = 1'b1;
      state_next   = START;
      timer_next   = div_in;
      bit_cnt_next = '0;
      shift_next   = word_masked;
      parity_next  = parity_in;
      nbits_next   = nbits_in;
      par_next     = par_in;
      stop2_next   = stop2;
      div_next     = div_in;
    end

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = IDLE_LEVEL;
    endcase
  end

  assign data_tx     = tx_reg;
  assign active_flag = (state_reg != IDLE);
  assign done_flag   = done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: frames are predicted bit-by-bit from the frame rules
// and FIFO occupancy from push/pop counting, then compared every cycle.
module tb_uart_tx_param;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [8:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  data_bits;
  logic [1:0]  parity_type;
  logic        stop2;
  logic [15:0] baud_div;
  logic        data_tx;
  logic        active_flag;
  logic        done_flag;
  logic [2:0]  fifo_level;

  uart_tx_param #(.DATA_W(9), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .data_bits   (data_bits),
    .parity_type (parity_type),
    .stop2       (stop2),
    .baud_div    (baud_div),
    .data_tx     (data_tx),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .fifo_level  (fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0]  words [8];
  logic [3:0]  a_bits, b_bits;
  logic [1:0]  a_par, b_par;
  logic        a_stop2, b_stop2;
  logic [15:0] a_div, b_div;
  int          change_k;
  int          abort_k;

  logic fb [8][16];
  int   pop_k [8];
  int   flen [8];
  int   fdiv [8];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_bits(input logic [3:0] b);
    if (b < 4'd5) return 5;
    if (b > 4'd9) return 9;
    return int'(b);
  endfunction

  function automatic int eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  task automatic set_cfg(input logic [3:0] b, input logic [1:0] p, input logic s2, input logic [15:0] d);
    a_bits = b; a_par = p; a_stop2 = s2; a_div = d;
    b_bits = b; b_par = p; b_stop2 = s2; b_div = d;
    change_k = 100000;
    abort_k  = -1;
  endtask

  // Inputs presented before edge kk.
  task automatic drive(input int kk, input int idx, input int n);
    s_valid = (idx < n);
    s_data  = (idx < n) ? words[idx] : 9'($urandom);
    if (kk < change_k) begin
      data_bits = a_bits; parity_type = a_par; stop2 = a_stop2; baud_div = a_div;
    end else begin
      data_bits = b_bits; parity_type = b_par; stop2 = b_stop2; baud_div = b_div;
    end
  endtask

  // Edge k counts posedges after the first word is offered; the first frame
  // is popped at edge 2 and each later frame right after the previous one.
  task automatic run_stream(input int n);
    int k, total, lvl, idx, nbits, ones, pos;
    logic push, pop, exp_tx, exp_act, exp_done;
    logic [3:0] b; logic [1:0] p; logic s2; logic [15:0] d;
    k = 2;
    for (int f = 0; f < n; f++) begin
      if (k < change_k) begin b = a_bits; p = a_par; s2 = a_stop2; d = a_div; end
      else begin b = b_bits; p = b_par; s2 = b_stop2; d = b_div; end
      nbits = eff_bits(b);
      fdiv[f] = eff_div(d);
      ones = 0;
      fb[f][0] = 1'b0;
      pos = 1;
      for (int i = 0; i < nbits; i++) begin
        fb[f][pos] = words[f][i];
        ones += int'(words[f][i]);
        pos++;
      end
      if (p == 2'b01) begin fb[f][pos] = (ones % 2 == 0); pos++; end
      else if (p == 2'b10) begin fb[f][pos] = (ones % 2 == 1); pos++; end
      fb[f][pos] = 1'b1; pos++;
      if (s2) begin fb[f][pos] = 1'b1; pos++; end
      pop_k[f] = k;
      flen[f]  = pos * fdiv[f];
      k += flen[f];
    end
    total = k + 3;
    lvl = 0;
    idx = 0;
    drive(1, idx, n);
    for (int kk = 1; kk <= total; kk++) begin
      @(posedge clock);
      pop = 1'b0;
      for (int f = 0; f < n; f++) if (pop_k[f] == kk) pop = 1'b1;
      push = (idx < n) && (lvl < DEPTH);
      if (push) idx++;
      lvl = lvl + int'(push) - int'(pop);
      @(negedge clock);
      exp_tx = 1'b1; exp_act = 1'b0; exp_done = 1'b0;
      for (int f = 0; f < n; f++) begin
        if (kk >= pop_k[f] && kk < pop_k[f] + flen[f]) begin
          exp_tx   = fb[f][(kk - pop_k[f]) / fdiv[f]];
          exp_act  = 1'b1;
          exp_done = (kk == pop_k[f] + flen[f] - 1);
        end
      end
      check("data_tx", 16'(data_tx), 16'(exp_tx));
      check("active_flag", 16'(active_flag), 16'(exp_act));
      check("done_flag", 16'(done_flag), 16'(exp_done));
      check("fifo_level", 16'(fifo_level), 16'(lvl));
      check("s_ready", 16'(s_ready), 16'(lvl < DEPTH));
      if (kk == abort_k) begin
        check("abort_in_data_low", 16'(data_tx), 16'(0));
        s_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_async_data_tx", 16'(data_tx), 16'(1));
        check("rst_async_active", 16'(active_flag), 16'(0));
        check("rst_async_level", 16'(fifo_level), 16'(0));
        check("rst_async_ready", 16'(s_ready), 16'(1));
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      drive(kk + 1, idx, n);
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0;
    data_bits = 4'd8; parity_type = 2'b00; stop2 = 1'b0; baud_div = 16'd4;
    repeat (2) @(negedge clock);
    check("reset_data_tx", 16'(data_tx), 16'(1));
    check("reset_active", 16'(active_flag), 16'(0));
    check("reset_done", 16'(done_flag), 16'(0));
    check("reset_ready", 16'(s_ready), 16'(1));
    check("reset_level", 16'(fifo_level), 16'(0));
    reset = 1'b0;
    @(negedge clock);

    // 8N1 div 4, 0xA5
    set_cfg(4'd8, 2'b00, 1'b0, 16'd4);
    words[0] = 9'h0A5;
    run_stream(1);

    // 8E1 / 8O1 div 2 on 0xA5, then 7E1 on 0x07
    set_cfg(4'd8, 2'b10, 1'b0, 16'd2);
    words[0] = 9'h0A5;
    run_stream(1);
    set_cfg(4'd8, 2'b01, 1'b0, 16'd2);
    run_stream(1);
    set_cfg(4'd7, 2'b10, 1'b0, 16'd2);
    words[0] = 9'h007;
    run_stream(1);

    // 5N2 div 3: 0x1F, then a word whose only set bits lie above bit 4
    set_cfg(4'd5, 2'b00, 1'b1, 16'd3);
    words[0] = 9'h01F;
    words[1] = 9'h1E0;
    run_stream(2);

    // Six back-to-back words with s_valid held: FIFO fills, frames contiguous
    set_cfg(4'd8, 2'b00, 1'b0, 16'd2);
    for (int i = 0; i < 6; i++) words[i] = 9'($urandom);
    run_stream(6);

    // Out-of-range data_bits and zero divisor
    set_cfg(4'd2, 2'b01, 1'b0, 16'd0);
    words[0] = 9'($urandom);
    words[1] = 9'($urandom);
    run_stream(2);
    set_cfg(4'd15, 2'b10, 1'b1, 16'd1);
    words[0] = 9'h1FF;
    run_stream(1);

    // Mid-frame change 8N1 div4 -> 8E1 div8 during DATA of the first frame
    set_cfg(4'd8, 2'b00, 1'b0, 16'd4);
    b_par = 2'b10;
    b_div = 16'd8;
    change_k = 14;
    words[0] = 9'($urandom);
    words[1] = 9'($urandom);
    run_stream(2);

    // Reset during DATA on an all-zero word, then a normal frame
    set_cfg(4'd8, 2'b00, 1'b0, 16'd4);
    words[0] = 9'h000;
    abort_k = 16;
    run_stream(1);
    set_cfg(4'd8, 2'b00, 1'b0, 16'd4);
    words[0] = 9'($urandom);
    run_stream(1);

    // Randomized formats, word counts and config-change points
    for (int r = 0; r < 5; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) words[i] = 9'($urandom);
      a_bits = 4'($urandom); a_par = 2'($urandom); a_stop2 = 1'($urandom);
      a_div = 16'($urandom_range(0, 4));
      b_bits = 4'($urandom); b_par = 2'($urandom); b_stop2 = 1'($urandom);
      b_div = 16'($urandom_range(0, 4));
      change_k = int'($urandom_range(2, 80));
      abort_k = -1;
      run_stream(n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
